// File: rtl/apb_mailbox_if.sv
// APB3 bus bundle for the mailbox responder; signal names are as seen from the responder.
interface apb_mailbox_if #(
    parameter int APB_ADDR_WIDTH = 12
) ();
    logic [APB_ADDR_WIDTH-1:0] paddr_i;
    logic [31:0]               pwdata_i;
    logic                      pwrite_i;
    logic                      psel_i;
    logic                      penable_i;
    logic [31:0]               prdata_o;
    logic                      pready_o;
    logic                      pslverr_o;

    modport slave (
        input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        input  prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_mailbox.sv
// Bidirectional 32-bit mailbox: APB-written TX FIFO drained by an agent stream,
// agent-filled RX FIFO read over APB, with status, flush, wait states and a level IRQ.
module apb_mailbox #(
    parameter int DEPTH          = 8,
    parameter int WAIT_STATES    = 0,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    apb_mailbox_if.slave apb,
    output logic        msg_valid_o,
    output logic [31:0] msg_data_o,
    input  logic        msg_ready_i,
    input  logic        msg_in_valid_i,
    input  logic [31:0] msg_in_data_i,
    output logic        msg_in_ready_o,
    output logic        irq_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [2:0]    WAIT_CNT = 3'(WAIT_STATES);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    // ---------------- APB access timing ----------------
    logic [2:0] wcnt_q, wcnt_d;
    logic       access;
    logic       complete;
    logic       addr_ok;
    logic [1:0] reg_sel;
    logic       wr_done;
    logic       rd_done;

    assign access   = apb.psel_i & apb.penable_i;
    assign complete = ~rst_i & access & (wcnt_q == WAIT_CNT);
    assign addr_ok  = (apb.paddr_i[APB_ADDR_WIDTH-1:4] == '0);
    assign reg_sel  = apb.paddr_i[3:2];
    assign wr_done  = complete & addr_ok & apb.pwrite_i;
    assign rd_done  = complete & addr_ok & ~apb.pwrite_i;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^apb.paddr_i[1:0];

    always_comb begin
        wcnt_d = wcnt_q;
        if (!apb.psel_i || complete) begin
            wcnt_d = '0;
        end else if (access && (wcnt_q < WAIT_CNT)) begin
            wcnt_d = wcnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    // ---------------- FIFO state ----------------
    logic [31:0]   tx_mem_q [DEPTH];
    logic [31:0]   rx_mem_q [DEPTH];
    logic [PW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [PW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          tx_push, tx_pop, tx_flush;
    logic          rx_push, rx_pop, rx_flush;
    logic          irq_en_q, irq_en_d;
    logic          irq_q, irq_d;

    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);

    // Full/empty come from registered counts, so same-cycle agent traffic never rescues an APB access.
    assign tx_push  = wr_done & (reg_sel == REG_TXDATA) & ~tx_full;
    assign tx_flush = wr_done & (reg_sel == REG_CTRL) & apb.pwdata_i[1];
    assign tx_pop   = msg_valid_o & msg_ready_i;

    assign rx_flush = wr_done & (reg_sel == REG_CTRL) & apb.pwdata_i[2];
    assign rx_pop   = rd_done & (reg_sel == REG_RXDATA) & ~rx_empty;
    assign rx_push  = msg_in_valid_i & msg_in_ready_o;

    assign msg_valid_o    = ~tx_empty;
    assign msg_data_o     = tx_empty ? 32'd0 : tx_mem_q[tx_rd_q];
    assign msg_in_ready_o = ~rst_i & ~rx_full & ~rx_flush;

    always_comb begin
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_flush) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_push) tx_wr_d = tx_wr_q + PW'(1);
            if (tx_pop)  tx_rd_d = tx_rd_q + PW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
                2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
                default: tx_cnt_d = tx_cnt_q;
            endcase
        end
    end

    always_comb begin
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_flush) begin
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (rx_push) rx_wr_d = rx_wr_q + PW'(1);
            if (rx_pop)  rx_rd_d = rx_rd_q + PW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
                2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
                default: rx_cnt_d = rx_cnt_q;
            endcase
        end
    end

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_done && (reg_sel == REG_CTRL)) begin
            irq_en_d = apb.pwdata_i[0];
        end
        irq_d = irq_en_d & (rx_cnt_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            tx_wr_q  <= tx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wr_q  <= rx_wr_d;
            rx_rd_q  <= rx_rd_d;
            rx_cnt_q <= rx_cnt_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    // Storage needs no reset: entries are only visible through the reset counters.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= apb.pwdata_i;
        if (rx_push) rx_mem_q[rx_wr_q] <= msg_in_data_i;
    end

    assign irq_o = irq_q;

    // ---------------- Read data and error response ----------------
    logic [31:0] status;
    logic [31:0] prdata_d;
    logic        pslverr_d;

    always_comb begin
        status        = '0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_full;
        status[3]     = rx_empty;
        status[12:8]  = 5'(tx_cnt_q);
        status[20:16] = 5'(rx_cnt_q);
    end

    always_comb begin
        prdata_d  = '0;
        pslverr_d = 1'b0;
        if (complete) begin
            if (!addr_ok) begin
                pslverr_d = 1'b1;
            end else begin
                case (reg_sel)
                    REG_TXDATA: pslverr_d = apb.pwrite_i & tx_full;
                    REG_RXDATA: begin
                        if (!apb.pwrite_i) begin
                            if (rx_empty) pslverr_d = 1'b1;
                            else          prdata_d  = rx_mem_q[rx_rd_q];
                        end
                    end
                    REG_STATUS: if (!apb.pwrite_i) prdata_d = status;
                    default:    if (!apb.pwrite_i) prdata_d = {31'd0, irq_en_q};
                endcase
            end
        end
    end

    assign apb.prdata_o  = prdata_d;
    assign apb.pslverr_o = pslverr_d;
    assign apb.pready_o  = complete;
endmodule

// File: tb/tb_apb_mailbox.sv
// Directed scoreboard bench for apb_mailbox with DEPTH=8 and two wait states.
module tb_apb_mailbox;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        msg_valid_o;
    logic [31:0] msg_data_o;
    logic        msg_ready_i;
    logic        msg_in_valid_i;
    logic [31:0] msg_in_data_i;
    logic        msg_in_ready_o;
    logic        irq_o;

    apb_mailbox_if #(.APB_ADDR_WIDTH(12)) apb_if ();

    apb_mailbox #(
        .DEPTH(8),
        .WAIT_STATES(2),
        .APB_ADDR_WIDTH(12)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .apb            (apb_if),
        .msg_valid_o    (msg_valid_o),
        .msg_data_o     (msg_data_o),
        .msg_ready_i    (msg_ready_i),
        .msg_in_valid_i (msg_in_valid_i),
        .msg_in_data_i  (msg_in_data_i),
        .msg_in_ready_o (msg_in_ready_o),
        .irq_o          (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_data_q[$];
    logic        exp_err_q[$];
    string       exp_name_q[$];

    logic ready_on_done = 1'b0;
    logic done_in_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every completed APB transfer is matched against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk_i);
            if (apb_if.psel_i && apb_if.penable_i && apb_if.pready_o) begin
                if (exp_data_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_completion: got prdata 0x%08h expected no transfer", apb_if.prdata_o);
                end else begin
                    logic [31:0] d;
                    logic        e;
                    string       n;
                    d = exp_data_q.pop_front();
                    e = exp_err_q.pop_front();
                    n = exp_name_q.pop_front();
                    $display("TXN %s addr=0x%03h wr=%0b prdata=0x%08h pslverr=%0b",
                             n, apb_if.paddr_i, apb_if.pwrite_i, apb_if.prdata_o, apb_if.pslverr_o);
                    check({n, "_prdata"}, apb_if.prdata_o, d);
                    check({n, "_pslverr"}, {31'd0, apb_if.pslverr_o}, {31'd0, e});
                end
            end
        end
    end

    task automatic apb_xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [31:0] exp_data, input logic exp_err, input string name,
                            output int waits);
        bit done;
        exp_data_q.push_back(exp_data);
        exp_err_q.push_back(exp_err);
        exp_name_q.push_back(name);
        @(posedge clk_i); #1;
        apb_if.paddr_i   = addr;
        apb_if.pwrite_i  = wr;
        apb_if.pwdata_i  = wdata;
        apb_if.psel_i    = 1'b1;
        apb_if.penable_i = 1'b0;
        @(posedge clk_i); #1;
        apb_if.penable_i = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk_i);
            if (apb_if.pready_o) begin
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 20) begin
                    checks++;
                    failures++;
                    $display("FAIL %s_timeout: got no pready after %0d cycles expected completion", name, waits);
                    done = 1'b1;
                end
            end
        end
        done_in_ready = msg_in_ready_o;
        if (ready_on_done) msg_ready_i = 1'b1;
        @(posedge clk_i); #1;
        apb_if.psel_i    = 1'b0;
        apb_if.penable_i = 1'b0;
        apb_if.pwrite_i  = 1'b0;
        msg_ready_i      = 1'b0;
        ready_on_done    = 1'b0;
    endtask

    task automatic apb_wr(input logic [11:0] addr, input logic [31:0] data, input logic err, input string name);
        int w;
        apb_xfer(addr, 1'b1, data, 32'd0, err, name, w);
    endtask

    task automatic apb_rd(input logic [11:0] addr, input logic [31:0] exp, input logic err, input string name);
        int w;
        apb_xfer(addr, 1'b0, 32'd0, exp, err, name, w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_i            = 1'b1;
        apb_if.paddr_i   = '0;
        apb_if.pwdata_i  = '0;
        apb_if.pwrite_i  = 1'b0;
        apb_if.psel_i    = 1'b0;
        apb_if.penable_i = 1'b0;
        msg_ready_i      = 1'b0;
        msg_in_valid_i   = 1'b0;
        msg_in_data_i    = '0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_in_ready", {31'd0, msg_in_ready_o}, 32'd0);
        check("rst_pready", {31'd0, apb_if.pready_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_in_ready", {31'd0, msg_in_ready_o}, 32'd1);
        check("post_rst_valid", {31'd0, msg_valid_o}, 32'd0);
        check("post_rst_data", msg_data_o, 32'd0);
        check("post_rst_irq", {31'd0, irq_o}, 32'd0);

        apb_rd(12'h008, 32'h0000_000A, 1'b0, "status_reset");

        // TX single write with wait states
        apb_xfer(12'h000, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0, "tx_first", w);
        check("tx_first_waits", w, 32'd2);
        @(negedge clk_i);
        check("tx_first_valid", {31'd0, msg_valid_o}, 32'd1);
        check("tx_first_data", msg_data_o, 32'hDEAD_BEEF);
        apb_xfer(12'h008, 1'b0, 32'd0, 32'h0000_0108, 1'b0, "status_tx1", w);
        check("rd_waits", w, 32'd2);

        // Fill TX, overflow with a same-cycle agent pop
        for (int i = 1; i < 8; i++) apb_wr(12'h000, 32'h100 + i, 1'b0, "tx_fill");
        apb_rd(12'h008, 32'h0000_0809, 1'b0, "status_tx_full");
        ready_on_done = 1'b1;
        apb_wr(12'h000, 32'h9999_9999, 1'b1, "tx_overflow");
        apb_rd(12'h008, 32'h0000_0708, 1'b0, "status_tx7");
        msg_ready_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk_i);
            check("tx_drain_data", msg_data_o, 32'h100 + i);
            @(posedge clk_i);
        end
        #1 msg_ready_i = 1'b0;
        @(negedge clk_i);
        check("tx_drained_valid", {31'd0, msg_valid_o}, 32'd0);
        check("tx_drained_data", msg_data_o, 32'd0);

        // RX with interrupt
        apb_wr(12'h00C, 32'h1, 1'b0, "ctrl_irq_en");
        apb_rd(12'h00C, 32'h1, 1'b0, "ctrl_rd");
        msg_in_valid_i = 1'b1;
        msg_in_data_i  = 32'h11;
        @(negedge clk_i);
        check("irq_before_push", {31'd0, irq_o}, 32'd0);
        check("rx_in_ready", {31'd0, msg_in_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        msg_in_data_i = 32'h22;
        @(negedge clk_i);
        check("irq_after_push", {31'd0, irq_o}, 32'd1);
        @(posedge clk_i); #1;
        msg_in_valid_i = 1'b0;
        apb_rd(12'h004, 32'h11, 1'b0, "rx_rd1");
        @(negedge clk_i);
        check("irq_after_rd1", {31'd0, irq_o}, 32'd1);
        apb_rd(12'h004, 32'h22, 1'b0, "rx_rd2");
        @(negedge clk_i);
        check("irq_after_rd2", {31'd0, irq_o}, 32'd0);
        apb_rd(12'h004, 32'h0, 1'b1, "rx_underflow");

        // Fill RX then flush with the agent still offering data
        msg_in_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            msg_in_data_i = 32'h200 + i;
            @(negedge clk_i);
            check("rx_fill_ready", {31'd0, msg_in_ready_o}, 32'd1);
            @(posedge clk_i); #1;
        end
        @(negedge clk_i);
        check("rx_full_ready", {31'd0, msg_in_ready_o}, 32'd0);
        check("rx_full_irq", {31'd0, irq_o}, 32'd1);
        apb_rd(12'h008, 32'h0008_0006, 1'b0, "status_rx_full");
        apb_wr(12'h00C, 32'h5, 1'b0, "rx_flush_full");
        msg_in_valid_i = 1'b0;
        check("flush_full_in_ready", {31'd0, done_in_ready}, 32'd0);
        @(negedge clk_i);
        check("irq_after_flush", {31'd0, irq_o}, 32'd0);
        apb_rd(12'h008, 32'h0000_000A, 1'b0, "status_after_flush");
        apb_rd(12'h00C, 32'h1, 1'b0, "ctrl_after_flush");

        // Partial RX flush: flush beats the agent push in the completion cycle
        msg_in_valid_i = 1'b1;
        msg_in_data_i  = 32'h333;
        apb_wr(12'h00C, 32'h5, 1'b0, "rx_flush_partial");
        msg_in_valid_i = 1'b0;
        check("flush_partial_in_ready", {31'd0, done_in_ready}, 32'd0);
        apb_rd(12'h008, 32'h0000_000A, 1'b0, "status_after_partial");

        // TX flush wins over a same-cycle agent pop
        apb_wr(12'h000, 32'hA1, 1'b0, "tx_a1");
        apb_wr(12'h000, 32'hA2, 1'b0, "tx_a2");
        ready_on_done = 1'b1;
        apb_wr(12'h00C, 32'h3, 1'b0, "tx_flush");
        @(negedge clk_i);
        check("tx_flush_valid", {31'd0, msg_valid_o}, 32'd0);
        apb_rd(12'h008, 32'h0000_000A, 1'b0, "status_after_txflush");

        // Address decode and ignored writes
        apb_wr(12'h010, 32'h0000_0006, 1'b1, "bad_addr_wr");
        apb_rd(12'h010, 32'h0, 1'b1, "bad_addr_rd");
        apb_rd(12'h00C, 32'h1, 1'b0, "ctrl_after_bad");
        apb_wr(12'h008, 32'hFFFF_FFFF, 1'b0, "status_wr");
        apb_wr(12'h004, 32'h1234_5678, 1'b0, "rxdata_wr");
        apb_rd(12'h008, 32'h0000_000A, 1'b0, "status_unchanged");
        apb_rd(12'h000, 32'h0, 1'b0, "txdata_rd");

        repeat (3) @(posedge clk_i);
        check("scoreboard_drained", exp_data_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_mailbox.md
Name: apb_mailbox

Overview:
- APB3 responder on one of the core complex APB slave slots. Carries 32-bit messages in both directions between software on the hart and an external agent using valid/ready streams.
- TX FIFO: written by APB, drained by the agent. RX FIFO: filled by the agent, read by APB.
- Provides status/count registers, per-FIFO flush, a programmable wait-state count and a level interrupt.

Parameters:
- DEPTH, 8, entries per FIFO; power of two, 2..16.
- WAIT_STATES, 0, access-phase cycles with pready_o low before completion; 0..7.
- APB_ADDR_WIDTH, 12, width of paddr_i.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- paddr_i  in  APB_ADDR_WIDTH  byte address; only [3:2] decoded, upper bits must be 0.
- pwdata_i  in  32  write data.
- pwrite_i  in  1  1 = write.
- psel_i  in  1  select.
- penable_i  in  1  access phase.
- prdata_o  out  32  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  transfer error.
- msg_valid_o  out  1  TX head available.
- msg_data_o  out  32  TX head data.
- msg_ready_i  in  1  agent accepts TX head.
- msg_in_valid_i  in  1  agent offers RX data.
- msg_in_data_i  in  32  RX data.
- msg_in_ready_o  out  1  RX FIFO accepts.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset: both FIFOs empty; CTRL = 0; wait counter = 0. Outputs: pready_o, pslverr_o, prdata_o, msg_valid_o, msg_data_o, irq_o = 0; msg_in_ready_o = 0 while rst_i = 1.
- Reset mid-transfer aborts the transfer with no FIFO side effect.
- APB phases: setup = psel_i & ~penable_i; access = psel_i & penable_i.
- Wait counter: increments each access cycle while below WAIT_STATES; clears whenever psel_i = 0 or on completion.
- Completion: pready_o = access & (wcnt == WAIT_STATES), combinational from the registered counter. WAIT_STATES = 0 gives zero-wait access.
- Side effects (push, pop, CTRL write) happen only in the completion cycle, exactly once per transfer.
- prdata_o and pslverr_o are valid only when pready_o = 1 and are 0 otherwise.
- Register map (paddr_i[3:2]):
  - 0x0 TXDATA: write pushes pwdata_i; read returns 0.
  - 0x4 RXDATA: read returns the RX head and pops it; write is ignored, no error.
  - 0x8 STATUS, read-only: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [12:8] tx_count, [20:16] rx_count, others 0. Write is ignored, no error.
  - 0xC CTRL: [0] irq_en (RW); [1] tx_flush, [2] rx_flush (write-1 pulse, read 0).
  - Any address with upper bits nonzero: pslverr_o = 1, prdata_o = 0, no effect.
- Error cases:
  - TXDATA write while tx_full: pslverr_o = 1, no push.
  - RXDATA read while rx_empty: pslverr_o = 1, prdata_o = 0, no pop.
  - Full/empty are sampled from registered state at the start of the cycle. A same-cycle agent pop does not make room for the APB push, and a same-cycle agent push does not satisfy the APB read.
- TX stream: msg_valid_o = ~tx_empty; msg_data_o = head, or 0 when empty. Pop on msg_valid_o & msg_ready_i. A simultaneous APB push and agent pop leaves the count unchanged.
- RX stream: msg_in_ready_o = ~rx_full & ~rx_flush_now. Push on msg_in_valid_i & msg_in_ready_o. A simultaneous agent push and APB pop leaves the count unchanged.
- Flush: takes effect at the completion edge; pointers and count go to 0.
  - Flush wins over a same-cycle agent pop (TX) or agent push (RX).
  - msg_in_ready_o is 0 during an RX-flush completion cycle.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits and saturate logically at DEPTH.
- irq_o: registered; irq_o <= irq_en_next & ~rx_empty_next, so it asserts one cycle after the causing edge.

Test Plan:
- Reset, then read STATUS -> prdata 0x0000_000A (tx_empty, rx_empty); irq_o = 0; msg_in_ready_o = 1.
- WAIT_STATES = 2: write TXDATA 0xDEADBEEF -> pready_o low for 2 access cycles, high on the 3rd. Then msg_valid_o = 1, msg_data_o = 0xDEADBEEF, STATUS[12:8] = 1.
- Push 8 words, then a 9th -> pslverr_o = 1, tx_count stays 8. On the same cycle assert msg_ready_i -> count 7 after the edge; the 9th word is absent.
- Agent pushes 0x11, 0x22 with irq_en = 1 -> irq_o rises 1 cycle after the first push. Read RXDATA twice -> 0x11, 0x22, irq_o falls; a 3rd read -> pslverr_o = 1, prdata_o = 0.
- RX full (8 entries), write CTRL = 0x4 while msg_in_valid_i = 1 -> msg_in_ready_o = 0 that cycle, rx_count = 0 after, irq_o deasserts.
- Write to 0x010 -> pslverr_o = 1, no state change. Write STATUS -> pslverr_o = 0, STATUS unchanged.
